// File: rtl/ovf_monitor.sv
// Registered add/sub overflow detector with sticky flag, saturating event counter and first-fault capture.
// Optional trap request/acknowledge handshake is built when OVF_TRAP_EN is defined.
module ovf_monitor #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 carry_out,
    input  logic                 is_sub,
    input  logic                 sign,
    input  logic                 clr_sticky,
    output logic                 of,
    output logic                 of_valid,
    output logic                 sticky_of,
    output logic [CNT_WIDTH-1:0] of_count,
    output logic [WIDTH-1:0]     cap_A,
    output logic [WIDTH-1:0]     cap_B,
    output logic                 cap_sub,
    output logic                 cap_valid,
    output logic                 trap_req,
    input  logic                 trap_ack
);

    localparam int M = WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic ovf_raw;
    logic event_hit;
    logic unused_sum_low;

    // Only the sign bit of the adder result matters; the signed subtract case
    // compares against B un-inverted, so the sign test flips relative to add.
    always_comb begin
        ovf_raw = 1'b0;
        if (in_valid) begin
            if (sign) begin
                if (is_sub)
                    ovf_raw = (A[M] != B[M]) && (sum[M] != A[M]);
                else
                    ovf_raw = (A[M] == B[M]) && (sum[M] != A[M]);
            end else begin
                ovf_raw = is_sub ? ~carry_out : carry_out;
            end
        end
    end

    assign event_hit      = in_valid & ovf_raw;
    assign unused_sum_low = ^sum[M-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            of        <= 1'b0;
            of_valid  <= 1'b0;
            sticky_of <= 1'b0;
            of_count  <= '0;
            cap_A     <= '0;
            cap_B     <= '0;
            cap_sub   <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            of       <= ovf_raw;
            of_valid <= in_valid;
            if (clr_sticky) begin
                sticky_of <= 1'b0;
                of_count  <= '0;
                cap_A     <= '0;
                cap_B     <= '0;
                cap_sub   <= 1'b0;
                cap_valid <= 1'b0;
            end
            // A simultaneous clear acts first, so the event then lands on clean state.
            if (event_hit) begin
                sticky_of <= 1'b1;
                if (clr_sticky)
                    of_count <= CNT_ONE;
                else if (of_count != CNT_MAX)
                    of_count <= of_count + 1'b1;
                if (clr_sticky || !cap_valid) begin
                    cap_A     <= A;
                    cap_B     <= B;
                    cap_sub   <= is_sub;
                    cap_valid <= 1'b1;
                end
            end
        end
    end

`ifdef OVF_TRAP_EN
    // Handshake: trap_req rises the cycle after an overflow event and stays high
    // until trap_ack is seen; the request is not re-armed until clr_sticky.
    localparam logic [1:0] TRAP_IDLE = 2'd0;
    localparam logic [1:0] TRAP_REQ  = 2'd1;
    localparam logic [1:0] TRAP_HOLD = 2'd2;

    logic [1:0] trap_state;
    logic [1:0] trap_next;

    always_comb begin
        trap_next = trap_state;
        case (trap_state)
            TRAP_IDLE: if (event_hit)  trap_next = TRAP_REQ;
            TRAP_REQ:  if (trap_ack)   trap_next = TRAP_HOLD;
            TRAP_HOLD: if (clr_sticky) trap_next = TRAP_IDLE;
            default:                   trap_next = TRAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trap_state <= TRAP_IDLE;
        else
            trap_state <= trap_next;
    end

    assign trap_req = (trap_state == TRAP_REQ);
`else
    logic unused_trap_ack;

    assign unused_trap_ack = trap_ack;
    assign trap_req        = 1'b0;
`endif

endmodule

// File: tb/tb_ovf_monitor.sv
// Scoreboard bench for ovf_monitor: an arithmetic reference model pushes expected
// output vectors per driven cycle; each scenario task pops and compares them.
module tb_ovf_monitor;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 8;
    localparam int EW        = 3 + CNT_WIDTH + 2 * WIDTH + 3;

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               sub;
        bit               sg;
        bit               clr;
        bit               ack;
    } op_t;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [WIDTH-1:0]     sum;
    logic                 carry_out;
    logic                 is_sub;
    logic                 sign;
    logic                 clr_sticky;
    logic                 of;
    logic                 of_valid;
    logic                 sticky_of;
    logic [CNT_WIDTH-1:0] of_count;
    logic [WIDTH-1:0]     cap_A;
    logic [WIDTH-1:0]     cap_B;
    logic                 cap_sub;
    logic                 cap_valid;
    logic                 trap_req;
    logic                 trap_ack;

    ovf_monitor #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .sum(sum),
        .carry_out(carry_out), .is_sub(is_sub), .sign(sign), .clr_sticky(clr_sticky),
        .of(of), .of_valid(of_valid), .sticky_of(sticky_of), .of_count(of_count),
        .cap_A(cap_A), .cap_B(cap_B), .cap_sub(cap_sub), .cap_valid(cap_valid),
        .trap_req(trap_req), .trap_ack(trap_ack)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit               m_of, m_ofv, m_sticky, m_capsub, m_capv;
    int               m_count;
    logic [WIDTH-1:0] m_capa, m_capb;
    int               m_trap;

    logic [EW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    function automatic logic [EW-1:0] obs_vec();
        return {of, of_valid, sticky_of, of_count, cap_A, cap_B, cap_sub, cap_valid, trap_req};
    endfunction

    function automatic logic [EW-1:0] model_vec();
        logic [CNT_WIDTH-1:0] c;
        c = m_count[CNT_WIDTH-1:0];
        return {m_of, m_ofv, m_sticky, c, m_capa, m_capb, m_capsub, m_capv, (m_trap == 1)};
    endfunction

    task automatic model_reset();
        m_of = 0; m_ofv = 0; m_sticky = 0; m_capsub = 0; m_capv = 0;
        m_count = 0; m_capa = '0; m_capb = '0; m_trap = 0;
    endtask

    // Overflow from true integer arithmetic, independent of bit-level rules.
    function automatic bit ref_ovf(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit sub, bit sg);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sg) begin
            r = sub ? sa - sb : sa + sb;
            return (r > (2 ** (WIDTH - 1)) - 1) || (r < -(2 ** (WIDTH - 1)));
        end
        return sub ? (ua < ub) : (ua + ub > (2 ** WIDTH) - 1);
    endfunction

    // driver: applies one cycle of adder-stage inputs and records the expectation
    task automatic step(input op_t op);
        logic [WIDTH:0] full;
        bit ov;
        @(negedge clk);
        in_valid   = op.v;
        A          = op.a;
        B          = op.b;
        is_sub     = op.sub;
        sign       = op.sg;
        clr_sticky = op.clr;
        trap_ack   = op.ack;
        if (op.sub)
            full = {1'b0, op.a} + {1'b0, ~op.b} + (WIDTH + 1)'(1);
        else
            full = {1'b0, op.a} + {1'b0, op.b};
        sum       = full[WIDTH-1:0];
        carry_out = full[WIDTH];

        ov = op.v && ref_ovf(op.a, op.b, op.sub, op.sg);
        m_of  = ov;
        m_ofv = op.v;
        if (op.clr) begin
            m_sticky = 0; m_count = 0; m_capa = '0; m_capb = '0; m_capsub = 0; m_capv = 0;
        end
        if (ov) begin
            m_sticky = 1;
            if (m_count < (2 ** CNT_WIDTH) - 1) m_count = m_count + 1;
            if (!m_capv) begin
                m_capa = op.a; m_capb = op.b; m_capsub = op.sub; m_capv = 1;
            end
        end
`ifdef OVF_TRAP_EN
        case (m_trap)
            0: if (ov) m_trap = 1;
            1: if (op.ack) m_trap = 2;
            default: if (op.clr) m_trap = 0;
        endcase
`endif
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(bit v, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                               bit sub, bit sg, bit clr, bit ack);
        op_t o;
        o.v = v; o.a = a; o.b = b; o.sub = sub; o.sg = sg; o.clr = clr; o.ack = ack;
        return o;
    endfunction

    // Brings state back to IDLE/cleared from any trap state; these cycles are not scored.
    task automatic settle();
        logic [EW-1:0] drop;
        repeat (2) begin
            step(mk(0, '0, '0, 0, 0, 1, 1));
            drop = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        logic [EW-1:0] got, exp;
        rst = 1'b1;
        in_valid = 0; A = '0; B = '0; sum = '0; carry_out = 0;
        is_sub = 0; sign = 0; clr_sticky = 0; trap_ack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        exp_q.push_back(model_vec());
        got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_held: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        step(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL reset_release: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_detect();
        op_t ops[12];
        logic [EW-1:0] got, exp;
        ops[0]  = mk(1, 16'h7FFF, 16'h0001, 0, 1, 0, 0);
        ops[1]  = mk(1, 16'hFFFF, 16'h0001, 0, 0, 0, 0);
        ops[2]  = mk(1, 16'hFFFF, 16'h0001, 0, 1, 0, 0);
        ops[3]  = mk(0, 16'hFFFF, 16'h0001, 0, 0, 0, 0);
        ops[4]  = mk(1, 16'h8000, 16'h0001, 1, 1, 0, 0);
        ops[5]  = mk(1, 16'h0001, 16'h0002, 1, 0, 0, 0);
        ops[6]  = mk(1, 16'h0005, 16'h0003, 1, 0, 0, 0);
        ops[7]  = mk(1, 16'h8000, 16'h8000, 0, 1, 0, 0);
        ops[8]  = mk(1, 16'h7FFF, 16'h8000, 1, 1, 0, 0);
        ops[9]  = mk(1, 16'h0000, 16'h0000, 1, 0, 0, 0);
        ops[10] = mk(1, 16'h8000, 16'h7FFF, 0, 1, 0, 0);
        ops[11] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        settle();
        for (int i = 0; i < 12; i++) begin
            step(ops[i]);
            got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL detect[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturate();
        logic [EW-1:0] got, exp;
        settle();
        for (int i = 0; i < 300; i++) begin
            if (i == 0)
                step(mk(1, 16'h7FFF, 16'h0001, 0, 1, 0, 0));
            else
                step(mk(1, 16'hFFFF, WIDTH'($urandom_range(1, 16'hFFFF)), 0, 0, 0, 0));
            got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL saturate[%0d]: got %h expected %h", i, got, exp);
            end
        end
        n_vec++;
        if (of_count !== 8'hFF || cap_A !== 16'h7FFF) begin
            n_err++; $display("FAIL saturate_end: got count %h capA %h expected ff 7fff", of_count, cap_A);
        end
        step(mk(1, 16'h1234, 16'hF000, 0, 0, 1, 0));
        got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL clear_collide: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_trap();
        op_t ops[11];
        logic [EW-1:0] got, exp;
        ops[0]  = mk(1, 16'h7FFF, 16'h0001, 0, 1, 0, 0);
        ops[1]  = mk(1, 16'hFFFF, 16'h0002, 0, 0, 0, 0);
        ops[2]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        ops[3]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        ops[4]  = mk(0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        ops[5]  = mk(1, 16'h0001, 16'h0002, 1, 0, 0, 0);
        ops[6]  = mk(1, 16'h4000, 16'h4000, 0, 1, 1, 0);
        ops[7]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        ops[8]  = mk(1, 16'h8000, 16'h0001, 1, 1, 1, 0);
        ops[9]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        ops[10] = mk(1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        settle();
        for (int i = 0; i < 11; i++) begin
            step(ops[i]);
            got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL trap[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        logic [EW-1:0] got, exp;
        for (int i = 0; i < 200; i++) begin
            o.v   = ($urandom_range(0, 4) != 0);
            o.a   = ($urandom_range(0, 3) == 0) ? WIDTH'(16'h8000 - $urandom_range(0, 1)) : WIDTH'($urandom);
            o.b   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom);
            o.sub = $urandom_range(0, 1) == 1;
            o.sg  = $urandom_range(0, 1) == 1;
            o.clr = ($urandom_range(0, 15) == 0);
            o.ack = ($urandom_range(0, 3) == 0);
            step(o);
            got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] got, exp;
        settle();
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 16'h7FFF, WIDTH'(i + 1), 0, 1, 0, 0));
            got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL pre_reset[%0d]: got %h expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        in_valid = 0;
        #2 rst = 1'b1;
        model_reset();
        exp_q.push_back(model_vec());
        #1;
        got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", got, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        step(mk(1, 16'h7FFF, 16'h0001, 0, 1, 0, 0));
        got = obs_vec(); exp = exp_q.pop_front(); n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL post_reset: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_detect();
        test_saturate();
        test_trap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ovf_monitor.md
Name: ovf_monitor

Overview:
Parametrised, registered overflow detector and status tracker for the execute stage. It generalises signed/unsigned add overflow detection to any WIDTH and adds subtraction, per-op valid qualification, a sticky flag, a saturating event counter and first-fault operand capture. It sits after the ALU adder; the decode/control logic supplies the qualifying valid. The optional trap handshake reports overflow to control.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
CNT_WIDTH, 8, width of saturating overflow event counter (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  qualifies operands this cycle (caller does opcode filtering)
A  input  WIDTH  adder operand A
B  input  WIDTH  adder operand B (un-inverted, even for subtract)
sum  input  WIDTH  adder result
carry_out  input  1  carry out of adder MSB
is_sub  input  1  1 = A-B computed as A+~B+1; 0 = A+B
sign  input  1  1 = signed check, 0 = unsigned check
clr_sticky  input  1  clears sticky_of, of_count, capture
of  output  1  registered overflow result for last valid op
of_valid  output  1  of is meaningful this cycle
sticky_of  output  1  any overflow since last clear
of_count  output  CNT_WIDTH  saturating overflow count
cap_A  output  WIDTH  A of first overflow since clear
cap_B  output  WIDTH  B of first overflow since clear
cap_sub  output  1  is_sub of first overflow
cap_valid  output  1  capture registers hold data
trap_req  output  1  overflow trap request (OVF_TRAP_EN only)
trap_ack  input  1  trap acknowledge (OVF_TRAP_EN only)

Behaviour:
- Reset: every output and all state = 0; trap FSM = IDLE. Async assert, deassert on clock edge.
- Detection (combinational, M = WIDTH-1), ovf_raw:
  - signed add: A[M]==B[M] and sum[M]!=A[M]
  - signed sub: A[M]!=B[M] and sum[M]!=A[M]
  - unsigned add: carry_out
  - unsigned sub: ~carry_out (borrow)
  - ovf_raw forced 0 when in_valid=0.
- Latency 1: of <= ovf_raw, of_valid <= in_valid each edge; no valid -> of=0, of_valid=0.
- Event = in_valid & ovf_raw. On event: sticky_of set; of_count +1, holding at all-ones (no wrap); if cap_valid=0, capture A, B, is_sub, set cap_valid. Later events do not overwrite capture.
- clr_sticky: sticky_of, of_count, cap_valid, capture regs -> 0 next edge.
- clr_sticky and event same cycle: clear applied first, then event: sticky_of=1, of_count=1, capture = current operands.
- Unaffected by clr_sticky: of/of_valid.
- Trap FSM (OVF_TRAP_EN):
  - IDLE: event -> REQ.
  - REQ: trap_req=1 (registered, first visible the cycle after the event, same cycle as of=1); held until trap_ack=1 -> HOLD.
  - HOLD: trap_req=0; wait clr_sticky=1 -> IDLE.
  - Events in REQ/HOLD: counted only, no new request.
  - trap_ack outside REQ: ignored.
  - clr_sticky in REQ: FSM stays in REQ (request must be acked); in HOLD same-cycle event: -> IDLE, no re-request until the next event.
- Reset mid-operation: immediate return to reset state, incl. REQ dropping trap_req.

Optional Feature:
OVF_TRAP_EN: defined -> trap FSM, trap_req and trap_ack as above. Undefined -> no FSM; trap_req tied 0, trap_ack ignored; all other behaviour identical.

Test Plan:
- WIDTH=16, signed add 0x7FFF+0x0001, sum=0x8000, co=0 -> next cycle of=1, of_valid=1, sticky_of=1, of_count=1, cap_A=0x7FFF, cap_B=0x0001.
- Unsigned add 0xFFFF+0x0001, sum=0x0000, co=1 -> of=1; same operands with sign=1 -> of=0; in_valid=0 with co=1 -> of=0, count unchanged.
- Signed sub 0x8000-0x0001, sum=0x7FFF, co=1 -> of=1; unsigned sub 0x0001-0x0002, sum=0xFFFF, co=0 -> of=1; unsigned sub 0x0005-0x0003, co=1 -> of=0.
- CNT_WIDTH=8: 300 back-to-back overflows -> of_count=0xFF, cap_A holds first op; clr_sticky with concurrent overflow -> of_count=1, capture = that op.
- OVF_TRAP_EN: overflow -> trap_req=1 next cycle; second overflow while in REQ -> count 2, trap_req stays 1; trap_ack -> trap_req=0 next cycle; clr_sticky -> IDLE; new overflow -> trap_req=1 again.
- Assert rst in REQ with count=3 -> all outputs 0 immediately, not waiting for clk.
